window_fetch: RTL and testbench

//  Downstream consumer of the 3x3 neighbourhood index stage on the N x N image path.

---
 rtl/window_fetch.sv | 127 ++++++++++++
 tb/tb_window_fetch.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/window_fetch.sv
// 3x3 window fetcher: reads the nine neighbourhood pixels from a single-port
// synchronous RAM, zero-pads out-of-image positions, and presents the window with a done pulse.
module window_fetch #(
  parameter int unsigned          N   = 64,
  parameter int unsigned          AW  = 12,
  parameter int unsigned          DW  = 8,
  parameter logic [DW-1:0]        PAD = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [$clog2(N)-1:0]    i,
  input  logic [$clog2(N)-1:0]    j,
  input  logic [AW-1:0]           l0,
  input  logic [AW-1:0]           l1,
  input  logic [AW-1:0]           l2,
  input  logic [AW-1:0]           l3,
  input  logic [AW-1:0]           l4,
  input  logic [AW-1:0]           l5,
  input  logic [AW-1:0]           l6,
  input  logic [AW-1:0]           l7,
  input  logic [AW-1:0]           l8,
  output logic                    mem_rd,
  output logic [AW-1:0]           mem_addr,
  input  logic [DW-1:0]           mem_data,
  output logic                    busy,
  output logic                    done,
  output logic [DW-1:0]           p0,
  output logic [DW-1:0]           p1,
  output logic [DW-1:0]           p2,
  output logic [DW-1:0]           p3,
  output logic [DW-1:0]           p4,
  output logic [DW-1:0]           p5,
  output logic [DW-1:0]           p6,
  output logic [DW-1:0]           p7,
  output logic [DW-1:0]           p8
);

  localparam int unsigned IW = $clog2(N);

  typedef enum logic [1:0] {IDLE, READ, WAIT, DONE} state_t;

  state_t          state, state_d;
  logic [3:0]      idx;
  logic [8:0]      mask, new_mask;
  logic [AW-1:0]   lat_l [9];
  logic [DW-1:0]   win   [8];
  logic [DW-1:0]   p_q   [9];
  logic [AW-1:0]   l_in  [9];
  logic [2:0]      cap_slot;

  assign l_in = '{l0, l1, l2, l3, l4, l5, l6, l7, l8};

  // Data for the read issued at idx-1 arrives while idx is current
  assign cap_slot = 3'(idx - 4'd1);

  always_comb begin
    new_mask = '1;
    if (i == '0)          begin new_mask[0] = 1'b0; new_mask[1] = 1'b0; new_mask[2] = 1'b0; end
    if (i == IW'(N - 1))  begin new_mask[6] = 1'b0; new_mask[7] = 1'b0; new_mask[8] = 1'b0; end
    if (j == '0)          begin new_mask[0] = 1'b0; new_mask[3] = 1'b0; new_mask[6] = 1'b0; end
    if (j == IW'(N - 1))  begin new_mask[2] = 1'b0; new_mask[5] = 1'b0; new_mask[8] = 1'b0; end
  end

  always_comb begin
    state_d  = state;
    mem_rd   = 1'b0;
    mem_addr = '0;
    unique case (state)
      IDLE: if (start) state_d = READ;
      READ: begin
        mem_rd   = mask[idx];
        mem_addr = mask[idx] ? lat_l[idx] : '0;
        if (idx == 4'd8) state_d = WAIT;
      end
      WAIT:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      mask  <= '0;
      for (int unsigned k = 0; k < 9; k++) begin
        lat_l[k] <= '0;
        p_q[k]   <= '0;
      end
      for (int unsigned k = 0; k < 8; k++) win[k] <= '0;
    end else begin
      state <= state_d;
      unique case (state)
        IDLE: if (start) begin
          idx   <= '0;
          mask  <= new_mask;
          lat_l <= l_in;
        end
        READ: begin
          idx <= idx + 4'd1;
          if (idx != '0) win[cap_slot] <= mask[cap_slot] ? mem_data : PAD;
        end
        WAIT: begin
          // Slot 8 bypasses win and lands directly in the output register
          for (int unsigned k = 0; k < 8; k++) p_q[k] <= win[k];
          p_q[8] <= mask[8] ? mem_data : PAD;
        end
        default: ;
      endcase
    end
  end

  assign p0 = p_q[0];
  assign p1 = p_q[1];
  assign p2 = p_q[2];
  assign p3 = p_q[3];
  assign p4 = p_q[4];
  assign p5 = p_q[5];
  assign p6 = p_q[6];
  assign p7 = p_q[7];
  assign p8 = p_q[8];

endmodule

// File: tb/tb_window_fetch.sv
// Directed bench for window_fetch: cycle-by-cycle check of RAM strobes, busy/done timing
// and the presented window against hand-computed vectors.
module tb_window_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [5:0]  i, j;
  logic [11:0] l_in [9];
  logic        mem_rd;
  logic [11:0] mem_addr;
  logic [7:0]  mem_data;
  logic        busy, done;
  logic [7:0]  p_out [9];

  int checks = 0;
  int errors = 0;
  logic [71:0] prev_p = '0;

  always #5 clk = ~clk;

  // RAM model: returns low address byte one cycle after a read, junk otherwise
  always @(posedge clk) mem_data <= mem_rd ? mem_addr[7:0] : 8'hEE;

  window_fetch #(.N(64), .AW(12), .DW(8), .PAD(8'd0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .i(i), .j(j),
    .l0(l_in[0]), .l1(l_in[1]), .l2(l_in[2]), .l3(l_in[3]), .l4(l_in[4]),
    .l5(l_in[5]), .l6(l_in[6]), .l7(l_in[7]), .l8(l_in[8]),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .busy(busy), .done(done),
    .p0(p_out[0]), .p1(p_out[1]), .p2(p_out[2]), .p3(p_out[3]), .p4(p_out[4]),
    .p5(p_out[5]), .p6(p_out[6]), .p7(p_out[7]), .p8(p_out[8])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [107:0] lv9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {12'(a8), 12'(a7), 12'(a6), 12'(a5), 12'(a4), 12'(a3), 12'(a2), 12'(a1), 12'(a0)};
  endfunction

  function automatic logic [71:0] pv9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    return {8'(a8), 8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  task automatic check_p(input string name, input logic [71:0] exp);
    for (int k = 0; k < 9; k++)
      check($sformatf("%s p%0d", name, k), 32'(p_out[k]), 32'(exp[k*8 +: 8]));
  endtask

  // Call just after a posedge; the next posedge is the accept edge T.
  task automatic fetch(input string name, input logic [5:0] ti, input logic [5:0] tj,
                       input logic [107:0] lv, input logic [8:0] msk,
                       input logic [71:0] pv, input bit hold);
    i = ti; j = tj;
    for (int k = 0; k < 9; k++) l_in[k] = lv[k*12 +: 12];
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) begin
      start = 1'b0;
      i = 6'($urandom); j = 6'($urandom);
      for (int k = 0; k < 9; k++) l_in[k] = 12'($urandom);
    end
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      check($sformatf("%s busy c%0d", name, c), 32'(busy), 32'd1);
      check($sformatf("%s done c%0d", name, c), 32'(done), (c == 11) ? 32'd1 : 32'd0);
      if (c <= 9) begin
        check($sformatf("%s mem_rd c%0d", name, c), 32'(mem_rd), 32'(msk[c-1]));
        check($sformatf("%s mem_addr c%0d", name, c), 32'(mem_addr),
              msk[c-1] ? 32'(lv[(c-1)*12 +: 12]) : 32'd0);
      end else begin
        check($sformatf("%s mem_rd c%0d", name, c), 32'(mem_rd), 32'd0);
      end
      if (c == 11) check_p(name, pv);
      else if (c == 5) check_p({name, " hold"}, prev_p);
    end
    @(posedge clk); #1;
    check({name, " busy idle"}, 32'(busy), 32'd0);
    check({name, " done idle"}, 32'(done), 32'd0);
    prev_p = pv;
  endtask

  initial begin
    logic [107:0] l_t1;
    logic [71:0]  p_t1;
    l_t1 = lv9(595, 596, 597, 659, 660, 661, 723, 724, 725);
    p_t1 = pv9(83, 84, 85, 147, 148, 149, 211, 212, 213);

    rst_n = 1'b0; start = 1'b0; i = '0; j = '0;
    for (int k = 0; k < 9; k++) l_in[k] = '0;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset mem_rd", 32'(mem_rd), 32'd0);
    check("reset mem_addr", 32'(mem_addr), 32'd0);
    check_p("reset", '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    fetch("interior", 6'd10, 6'd20, l_t1, 9'h1FF, p_t1, 1'b0);
    fetch("corner00", 6'd0, 6'd0, lv9(4031, 4032, 4033, 4095, 0, 1, 63, 64, 65),
          9'b110110000, pv9(0, 0, 0, 0, 0, 1, 0, 64, 65), 1'b0);
    fetch("corner63", 6'd63, 6'd63, lv9(4030, 4031, 4032, 4094, 4095, 0, 62, 63, 64),
          9'b000011011, pv9(190, 191, 0, 254, 255, 0, 0, 0, 0), 1'b0);
    fetch("edge_j0", 6'd5, 6'd0, lv9(255, 256, 257, 319, 320, 321, 383, 384, 385),
          9'b110110110, pv9(0, 0, 1, 0, 64, 65, 0, 128, 129), 1'b0);

    // start held high across a whole fetch: second accept exactly 12 cycles later
    fetch("held_a", 6'd10, 6'd20, l_t1, 9'h1FF, p_t1, 1'b1);
    fetch("held_b", 6'd10, 6'd20, l_t1, 9'h1FF, p_t1, 1'b0);
    repeat (2) @(negedge clk) check("held idle done", 32'(done), 32'd0);

    // reset in the middle of a fetch
    @(posedge clk); #1;
    i = 6'd10; j = 6'd20;
    for (int k = 0; k < 9; k++) l_in[k] = l_t1[k*12 +: 12];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst mem_rd", 32'(mem_rd), 32'd0);
    check("midrst mem_addr", 32'(mem_addr), 32'd0);
    check_p("midrst", '0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("midrst done c%0d", c), 32'(done), 32'd0);
      if (c == 2) rst_n = 1'b1;
    end
    @(posedge clk); #1;
    prev_p = '0;
    fetch("after_rst", 6'd10, 6'd20, l_t1, 9'h1FF, p_t1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
